// File: rtl/time_report_tx_pkg.sv
// Shared definitions for the time report transmitter: state encoding,
// ASCII constants, frame lengths and index width.
package time_report_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int FRAME_LEN_CRLF    = 13;
  localparam int FRAME_LEN_NO_CRLF = 11;
  localparam int IDX_W             = 4;
  localparam int NUM_FIELDS        = 4;

endpackage

// File: rtl/time_report_tx_bin2dec99.sv
// Combinational 7-bit binary to two ASCII decimal digits, saturating at 99.
module bin2dec99
  import time_report_tx_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [6:0] clamped;
  logic [6:0] tens_val;
  logic [6:0] ones_val;

  always_comb begin
    clamped  = (value > 7'd99) ? 7'd99 : value;
    tens_val = clamped / 7'd10;
    ones_val = clamped % 7'd10;
    tens     = ASCII_ZERO + {1'b0, tens_val};
    ones     = ASCII_ZERO + {1'b0, ones_val};
  end

endmodule

// File: rtl/time_report_tx.sv
// Sends a snapshot of the time inputs as "HH:MM:SS.CC" (plus optional CR LF)
// one byte at a time over a valid/ready UART transmit interface.
module time_report_tx
  import time_report_tx_pkg::*;
#(
  parameter int SEND_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done
);

  localparam int FRAME_LEN = (SEND_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_NO_CRLF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [6:0]       snap_reg [NUM_FIELDS];
  logic [6:0]       field_in [NUM_FIELDS];
  logic [7:0]       tens [NUM_FIELDS];
  logic [7:0]       ones [NUM_FIELDS];
  logic [7:0]       cur_byte;
  logic [7:0]       hold_reg;

  // Field order in the frame: hour, minute, second, centisecond.
  assign field_in[0] = {2'b00, i_hour};
  assign field_in[1] = {1'b0, i_min};
  assign field_in[2] = {1'b0, i_sec};
  assign field_in[3] = i_msec;

  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      bin2dec99 u_conv (
        .value (snap_reg[gi]),
        .tens  (tens[gi]),
        .ones  (ones[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      hold_reg  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) snap_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == ST_IDLE && i_req) begin
        for (int i = 0; i < NUM_FIELDS; i++) snap_reg[i] <= field_in[i];
      end
      // Remember the presented byte so the output holds it once the frame ends.
      if (state_reg == ST_SEND) hold_reg <= cur_byte;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_req) begin
          state_next = ST_SEND;
          idx_next   = '0;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (idx_reg == LAST_IDX) state_next = ST_DONE;
          else                     idx_next   = idx_reg + 4'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx_reg)
      4'd0:    cur_byte = tens[0];
      4'd1:    cur_byte = ones[0];
      4'd2:    cur_byte = ASCII_COLON;
      4'd3:    cur_byte = tens[1];
      4'd4:    cur_byte = ones[1];
      4'd5:    cur_byte = ASCII_COLON;
      4'd6:    cur_byte = tens[2];
      4'd7:    cur_byte = ones[2];
      4'd8:    cur_byte = ASCII_DOT;
      4'd9:    cur_byte = tens[3];
      4'd10:   cur_byte = ones[3];
      4'd11:   cur_byte = ASCII_CR;
      4'd12:   cur_byte = ASCII_LF;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    o_tx_valid = (state_reg == ST_SEND);
    o_busy     = (state_reg != ST_IDLE);
    o_done     = (state_reg == ST_DONE);
    o_tx_data  = (state_reg == ST_SEND) ? cur_byte : hold_reg;
  end

endmodule

// File: tb/tb_time_report_tx.sv
// Directed bench for time_report_tx: one instance with CR LF, one without.
module tb_time_report_tx;

  logic       clk = 1'b0;
  logic       rst, req, ready;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  int total = 0;
  int bad = 0;

  logic [7:0] got_q[$];
  int         done_cnt, extra_valid, done_cyc;
  logic [7:0] idle_data;

  always #5 clk = ~clk;

  time_report_tx #(.SEND_CRLF(1)) dut_crlf (
    .clk(clk), .rst(rst), .i_req(req), .i_msec(msec), .i_sec(sec), .i_min(min),
    .i_hour(hour), .o_tx_data(data_a), .o_tx_valid(valid_a), .i_tx_ready(ready),
    .o_busy(busy_a), .o_done(done_a)
  );

  time_report_tx #(.SEND_CRLF(0)) dut_nocrlf (
    .clk(clk), .rst(rst), .i_req(req), .i_msec(msec), .i_sec(sec), .i_min(min),
    .i_hour(hour), .o_tx_data(data_b), .o_tx_valid(valid_b), .i_tx_ready(ready),
    .o_busy(busy_b), .o_done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    msec = 7'(c);
  endtask

  // Pulse a request, then follow the chosen instance to its done pulse.
  // rdy_mode 0: ready always 1; 1: ready pattern 1,0,0 repeating.
  task automatic collect(input bit sel_b, input int rdy_mode, input bit poke,
                         input int abort_after, output bit aborted);
    bit v, dn, pv, pr, seen_done, abort_pend, poked;
    logic [7:0] d, pd;
    int extra;
    got_q.delete();
    done_cnt = 0; extra_valid = 0; done_cyc = -1; extra = 0;
    pv = 0; pr = 0; pd = 0; seen_done = 0; abort_pend = 0; poked = 0; aborted = 0;
    ready = 1'b1;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("latency_valid", sel_b ? valid_b : valid_a, 1);
    check("latency_busy", sel_b ? busy_b : busy_a, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      v  = sel_b ? valid_b : valid_a;
      d  = sel_b ? data_b : data_a;
      dn = sel_b ? done_b : done_a;
      req = 1'b0;
      if (abort_pend) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", sel_b ? valid_b : valid_a, 0);
        check("abort_busy", sel_b ? busy_b : busy_a, 0);
        check("abort_done", sel_b ? done_b : done_a, 0);
        check("abort_data", sel_b ? data_b : data_a, 0);
        aborted = 1;
        return;
      end
      if (seen_done && v) extra_valid++;
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (poke) req = 1'b1;
      end
      if (pv && !pr && v && !seen_done) check("stall_stable", d, pd);
      ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (v && !seen_done && poke && !poked && got_q.size() == 4) begin
        set_time(1, 2, 3, 4);
        req = 1'b1;
        poked = 1;
      end
      if (v && ready && !seen_done) begin
        got_q.push_back(d);
        if (abort_after > 0 && got_q.size() == abort_after) abort_pend = 1;
      end
      if (dn) seen_done = 1;
      pv = v; pr = ready; pd = d;
      if (seen_done) begin
        extra++;
        if (extra > 20) break;
      end
      @(negedge clk);
    end
    if (!seen_done) check("timeout_no_done", 0, 1);
    idle_data = sel_b ? data_b : data_a;
    ready = 1'b1;
    req = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input string s, input bit crlf);
    int n;
    logic [7:0] e, g;
    n = crlf ? s.len() + 2 : s.len();
    e = 8'h00;
    check({tag, "_len"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < s.len())       e = s[i];
      else if (i == s.len()) e = 8'h0D;
      else                   e = 8'h0A;
      g = (i < got_q.size()) ? got_q[i] : 8'h00;
      check($sformatf("%s_byte%0d", tag, i), g, e);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_extra_valid"}, extra_valid, 0);
    check({tag, "_idle_hold"}, idle_data, e);
    $display("%s: %0d bytes, done pulses %0d", tag, got_q.size(), done_cnt);
  endtask

  initial begin
    bit ab;
    rst = 1'b1; req = 1'b0; ready = 1'b1;
    set_time(9, 9, 9, 9);
    repeat (3) @(negedge clk);
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_data_b", data_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: back-to-back transfers
    set_time(5, 7, 42, 9);
    collect(0, 0, 0, 0, ab);
    expect_frame("s1", "05:07:42.09", 1);
    check("s1_done_cycle", done_cyc, 13);

    // Scenario 2: ready toggling 1,0,0
    collect(0, 1, 0, 0, ab);
    expect_frame("s2", "05:07:42.09", 1);

    // Scenario 3: clamp of centiseconds
    set_time(23, 59, 59, 120);
    collect(0, 0, 0, 0, ab);
    expect_frame("s3", "23:59:59.99", 1);

    // Scenario 4: input change and extra requests mid-frame and at done
    set_time(10, 20, 30, 40);
    collect(0, 0, 1, 0, ab);
    expect_frame("s4", "10:20:30.40", 1);

    // Scenario 5: reset after 6 bytes, then a clean frame
    set_time(5, 7, 42, 9);
    collect(0, 0, 0, 6, ab);
    check("s5_aborted", ab, 1);
    check("s5_bytes_before_abort", got_q.size(), 6);
    $display("s5: aborted after %0d bytes", got_q.size());
    collect(0, 0, 0, 0, ab);
    expect_frame("s5_restart", "05:07:42.09", 1);

    // Scenario 6: no CR LF, centiseconds at 100 clamp to 99
    set_time(12, 34, 56, 100);
    collect(1, 0, 0, 0, ab);
    expect_frame("s6", "12:34:56.99", 0);
    check("s6_done_cycle", done_cyc, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
